uart_config_bank: RTL

//  Multi-channel successor of the single-UART config register: one config bus feeds NUM_CH UART channels.
//  Per channel: parity mode, stop bits, data length, baud divisor.

---
 rtl/uart_config_bank_if.sv | 33 +++
 rtl/uart_config_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_config_bank_if.sv
// rtl/uart_config_bank_if.sv - config-bus handshake bundle for uart_config_bank
//
// Purpose: groups the write-only config bus between a master and the bank.
// Signals:
//   c_ch     channel select          (master -> bank)
//   c_addr   register address        (master -> bank)
//   c_data   write data              (master -> bank)
//   c_valid  write pending           (master -> bank)
//   c_ready  write accepted this cycle (bank -> master)
//   c_err    one-cycle reject pulse  (bank -> master)

interface uart_config_bank_if #(
  parameter int CH_W              = 2,
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_CONFIG_DATA = 8
);
  logic [CH_W-1:0]              c_ch;
  logic [WIDTH_CONFIG_ADDR-1:0] c_addr;
  logic [WIDTH_CONFIG_DATA-1:0] c_data;
  logic                         c_valid;
  logic                         c_ready;
  logic                         c_err;

  modport master (
    output c_ch, c_addr, c_data, c_valid,
    input  c_ready, c_err
  );

  modport slave (
    input  c_ch, c_addr, c_data, c_valid,
    output c_ready, c_err
  );
endinterface

// File: rtl/uart_config_bank.sv
// rtl/uart_config_bank.sv - multi-channel UART config bank with shadow/active registers
//
// Purpose: one config bus programs NUM_CH UART channels. Writes land in a
// per-channel shadow copy; each channel copies shadow to active only while
// its UART is idle. Illegal writes are discarded and flagged on c_err.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   cfg           config bus (slave side of uart_config_bank_if)
//   ch_busy       per-channel UART busy; blocks commit of that channel
//   parity_en     active parity enable per channel
//   parity_odd    active parity sense per channel (1 = odd)
//   stop2         active stop-bit select per channel (1 = two stop bits)
//   data_len      active data length, 2 bits per channel
//   baud_div      active baud divisor, 8 bits per channel
//   cfg_pending   shadow not yet committed to active

module uart_config_bank #(
  parameter int         NUM_CH            = 4,
  parameter int         CH_W              = 2,
  parameter int         WIDTH_CONFIG_ADDR = 4,
  parameter int         WIDTH_CONFIG_DATA = 8,
  parameter logic [7:0] BAUD_DIV_RST      = 8'd27
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_config_bank_if.slave     cfg,
  input  logic [NUM_CH-1:0]     ch_busy,
  output logic [NUM_CH-1:0]     parity_en,
  output logic [NUM_CH-1:0]     parity_odd,
  output logic [NUM_CH-1:0]     stop2,
  output logic [2*NUM_CH-1:0]   data_len,
  output logic [8*NUM_CH-1:0]   baud_div,
  output logic [NUM_CH-1:0]     cfg_pending
);

  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_PARITY = WIDTH_CONFIG_ADDR'(5);
  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_STOP   = WIDTH_CONFIG_ADDR'(6);
  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_DLEN   = WIDTH_CONFIG_ADDR'(7);
  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_BAUD   = WIDTH_CONFIG_ADDR'(8);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t state, state_n;
  logic   ready_q, ready_n;
  logic   err_q, err_n;
  logic   transfer;
  logic   reject;
  logic   addr_ok;
  logic   val_ok;
  logic   [NUM_CH-1:0] wr_en;

  // Shadow and active copies; parity is stored as {enable, odd}.
  logic [1:0] sh_par  [NUM_CH];
  logic       sh_stop [NUM_CH];
  logic [1:0] sh_dlen [NUM_CH];
  logic [7:0] sh_baud [NUM_CH];
  logic [1:0] ac_par  [NUM_CH];
  logic       ac_stop [NUM_CH];
  logic [1:0] ac_dlen [NUM_CH];
  logic [7:0] ac_baud [NUM_CH];

  assign cfg.c_ready = ready_q;
  assign cfg.c_err   = err_q;

  // Write decode and legality check.
  always_comb begin
    addr_ok = 1'b1;
    val_ok  = 1'b1;
    case (cfg.c_addr)
      ADDR_PARITY: val_ok = (cfg.c_data[1:0] != 2'b01);
      ADDR_STOP:   val_ok = 1'b1;
      ADDR_DLEN:   val_ok = 1'b1;
      ADDR_BAUD:   val_ok = (cfg.c_data[7:0] != 8'd0);
      default:     addr_ok = 1'b0;
    endcase
    reject = (int'(cfg.c_ch) >= NUM_CH) || !addr_ok || !val_ok;
  end

  // ready_q mirrors S_IDLE, so a transfer needs only the state and c_valid.
  assign transfer = (state == S_IDLE) && cfg.c_valid;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (transfer && !reject && (cfg.c_ch == CH_W'(i))) begin
        wr_en[i] = 1'b1;
      end
    end
  end

  // Handshake FSM: next state plus the values c_ready/c_err take after the edge.
  always_comb begin
    state_n = state;
    ready_n = 1'b1;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (transfer) begin
          state_n = S_ACK;
          ready_n = 1'b0;
          err_n   = reject;
        end
      end
      S_ACK: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      ready_q <= ready_n;
      err_q   <= err_n;
    end
  end

  // Per-channel shadow/active. Commit reads the pre-edge shadow, so a write
  // landing on a commit edge is kept pending for the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_pending <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_par[i]  <= 2'b00;
        sh_stop[i] <= 1'b0;
        sh_dlen[i] <= 2'b11;
        sh_baud[i] <= BAUD_DIV_RST;
        ac_par[i]  <= 2'b00;
        ac_stop[i] <= 1'b0;
        ac_dlen[i] <= 2'b11;
        ac_baud[i] <= BAUD_DIV_RST;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_pending[i] && !ch_busy[i]) begin
          ac_par[i]  <= sh_par[i];
          ac_stop[i] <= sh_stop[i];
          ac_dlen[i] <= sh_dlen[i];
          ac_baud[i] <= sh_baud[i];
        end
        if (wr_en[i]) begin
          cfg_pending[i] <= 1'b1;
          if (cfg.c_addr == ADDR_PARITY) sh_par[i]  <= cfg.c_data[1:0];
          if (cfg.c_addr == ADDR_STOP)   sh_stop[i] <= cfg.c_data[0];
          if (cfg.c_addr == ADDR_DLEN)   sh_dlen[i] <= cfg.c_data[1:0];
          if (cfg.c_addr == ADDR_BAUD)   sh_baud[i] <= cfg.c_data[7:0];
        end else if (cfg_pending[i] && !ch_busy[i]) begin
          cfg_pending[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign parity_en[g]        = ac_par[g][1];
    assign parity_odd[g]       = ac_par[g][0];
    assign stop2[g]            = ac_stop[g];
    assign data_len[2*g +: 2]  = ac_dlen[g];
    assign baud_div[8*g +: 8]  = ac_baud[g];
  end

endmodule
